// File: rtl/interfaz_pkg.sv
// Shared definitions for the UART-to-ALU interfaces (interfaz_rx / interfaz_tx):
// default data/opcode widths and the receive-side FSM state encodings.
package interfaz_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] S_A       = 3'd0;
  localparam logic [ST_W-1:0] S_B       = 3'd1;
  localparam logic [ST_W-1:0] S_OP      = 3'd2;
  localparam logic [ST_W-1:0] S_EXEC    = 3'd3;
  localparam logic [ST_W-1:0] S_WAIT_TX = 3'd4;

endpackage

// File: rtl/timer_inactividad.sv
// Inactivity timer: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES-1 cycles have elapsed.
module timer_inactividad #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter parks at the expiry value until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interfaz_rx.sv
// Collects operand A, operand B and opcode bytes from the UART receiver and
// hands them to the ALU. Optional inter-byte timeout: INTERFAZ_RX_TIMEOUT_EN.
module interfaz_rx
  import interfaz_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int NB_OP          = NB_OP_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_alu_valid,
  output logic               o_busy,
  output logic               o_timeout
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nx;
  logic            capture_a;
  logic            capture_b;
  logic            capture_op;
  logic            timeout_hit;
  logic            expired;

`ifdef INTERFAZ_RX_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  assign timer_enable = (state == S_B) || (state == S_OP);
  assign timer_clear  = !timer_enable || i_rx_done || timeout_hit;

  timer_inactividad #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expired    = 1'b0;
`endif

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_nx    = state;
    capture_a   = 1'b0;
    capture_b   = 1'b0;
    capture_op  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_A: begin
        if (i_rx_done) begin
          capture_a = 1'b1;
          state_nx  = S_B;
        end
      end
      S_B: begin
        if (i_rx_done) begin
          capture_b = 1'b1;
          state_nx  = S_OP;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_nx    = S_A;
        end
      end
      S_OP: begin
        if (i_rx_done) begin
          capture_op = 1'b1;
          state_nx   = S_EXEC;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_nx    = S_A;
        end
      end
      S_EXEC:    state_nx = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          state_nx = S_A;
        end
      end
      default:   state_nx = S_A;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_A;
      o_dato_a    <= '0;
      o_dato_b    <= '0;
      o_op        <= '0;
      o_alu_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state       <= state_nx;
      o_alu_valid <= (state_nx == S_EXEC);
      o_busy      <= (state_nx == S_EXEC) || (state_nx == S_WAIT_TX);
      o_timeout   <= timeout_hit;
      if (capture_a) begin
        o_dato_a <= i_rx_data;
      end
      if (capture_b) begin
        o_dato_b <= i_rx_data;
      end
      if (capture_op) begin
        o_op <= i_rx_data[NB_OP-1:0];
      end
    end
  end

endmodule

// File: tb/tb_interfaz_rx.sv
// Directed bench for interfaz_rx: per-cycle vector table plus reset and
// timeout sequences (timeout section follows INTERFAZ_RX_TIMEOUT_EN).
module tb_interfaz_rx;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] o_dato_a;
  logic [7:0] o_dato_b;
  logic [5:0] o_op;
  logic       o_alu_valid;
  logic       o_busy;
  logic       o_timeout;

  int n_pass  = 0;
  int n_total = 0;

  interfaz_rx #(
    .NB_DATA       (8),
    .NB_OP         (6),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_tx_done  (i_tx_done),
    .o_dato_a   (o_dato_a),
    .o_dato_b   (o_dato_b),
    .o_op       (o_op),
    .o_alu_valid(o_alu_valid),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    logic       rd;
    logic       td;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [5:0] eop;
    logic       ev;
    logic       ebusy;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic [7:0] d, input logic rd, input logic td);
    i_rx_data = d;
    i_rx_done = rd;
    i_tx_done = td;
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input logic v, input logic bz, input logic to);
    check({tag, ".dato_a"},    32'(o_dato_a),    32'(a));
    check({tag, ".dato_b"},    32'(o_dato_b),    32'(b));
    check({tag, ".op"},        32'(o_op),        32'(op));
    check({tag, ".alu_valid"}, 32'(o_alu_valid), 32'(v));
    check({tag, ".busy"},      32'(o_busy),      32'(bz));
    check({tag, ".timeout"},   32'(o_timeout),   32'(to));
  endtask

  initial begin
    //            d      rd    td    a      b      op     v     busy
    vecs[0]  = '{8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0}; // tx_done in S_A
    vecs[1]  = '{8'h04, 1'b1, 1'b0, 8'h04, 8'h00, 6'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 8'h04, 8'h00, 6'h00, 1'b0, 1'b0}; // tx_done in S_B
    vecs[3]  = '{8'h02, 1'b1, 1'b0, 8'h04, 8'h02, 6'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h20, 1'b1, 1'b0, 8'h04, 8'h02, 6'h20, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 8'h04, 8'h02, 6'h20, 1'b0, 1'b1};
    vecs[6]  = '{8'h55, 1'b1, 1'b0, 8'h04, 8'h02, 6'h20, 1'b0, 1'b1}; // dropped
    vecs[7]  = '{8'h00, 1'b0, 1'b1, 8'h04, 8'h02, 6'h20, 1'b0, 1'b0};
    vecs[8]  = '{8'h06, 1'b1, 1'b0, 8'h06, 8'h02, 6'h20, 1'b0, 1'b0};
    vecs[9]  = '{8'h03, 1'b1, 1'b0, 8'h06, 8'h03, 6'h20, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 1'b1, 8'h06, 8'h03, 6'h20, 1'b0, 1'b0}; // tx_done in S_OP
    vecs[11] = '{8'hE5, 1'b1, 1'b0, 8'h06, 8'h03, 6'h25, 1'b1, 1'b1};
    vecs[12] = '{8'h11, 1'b1, 1'b1, 8'h06, 8'h03, 6'h25, 1'b0, 1'b1}; // in S_EXEC
    vecs[13] = '{8'h77, 1'b1, 1'b1, 8'h06, 8'h03, 6'h25, 1'b0, 1'b0}; // rx+tx in WAIT_TX
    vecs[14] = '{8'h08, 1'b1, 1'b0, 8'h08, 8'h03, 6'h25, 1'b0, 1'b0};

    i_rst     = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all("reset", 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].d, vecs[i].rd, vecs[i].td);
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop,
                vecs[i].ev, vecs[i].ebusy, 1'b0);
    end

    // Async reset while in S_B, then a partial command, then reset again.
    #2;
    i_rst = 1'b0;
    #1;
    check_all("rst_async1", 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    step(8'h04, 1'b1, 1'b0);
    check_all("rst_partial", 8'h04, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    #2;
    i_rst = 1'b0;
    #1;
    check_all("rst_async2", 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    step(8'h07, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'h22, 1'b1, 1'b0);
    check_all("post_rst_cmd", 8'h07, 8'h01, 6'h22, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check_all("post_rst_wait", 8'h07, 8'h01, 6'h22, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    check_all("post_rst_done", 8'h07, 8'h01, 6'h22, 1'b0, 1'b0, 1'b0);

`ifdef INTERFAZ_RX_TIMEOUT_EN
    step(8'h03, 1'b1, 1'b0);
    check("to_a", 32'(o_dato_a), 32'h03);
    for (int i = 1; i <= 19; i++) begin
      step(8'h00, 1'b0, 1'b0);
      check($sformatf("to_idle%0d", i), 32'(o_timeout), 32'd0);
    end
    step(8'h00, 1'b0, 1'b0);
    check("to_pulse", 32'(o_timeout), 32'd1);
    step(8'h00, 1'b0, 1'b0);
    check("to_pulse_end", 32'(o_timeout), 32'd0);
    step(8'h09, 1'b1, 1'b0);
    check_all("to_next_a", 8'h09, 8'h01, 6'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      step(8'h00, 1'b0, 1'b0);
    end
    step(8'h0B, 1'b1, 1'b0);
    check_all("to_expiry_byte", 8'h09, 8'h0B, 6'h22, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("to_no_late_pulse", 32'(o_timeout), 32'd0);
    step(8'h01, 1'b1, 1'b0);
    check_all("to_cmd_done", 8'h09, 8'h0B, 6'h01, 1'b1, 1'b1, 1'b0);
`else
    step(8'h03, 1'b1, 1'b0);
    check("noto_a", 32'(o_dato_a), 32'h03);
    for (int i = 1; i <= 200; i++) begin
      step(8'h00, 1'b0, 1'b0);
      check($sformatf("noto_idle%0d", i), 32'(o_timeout), 32'd0);
    end
    step(8'h09, 1'b1, 1'b0);
    check_all("noto_b", 8'h03, 8'h09, 6'h22, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
